// File: rtl/sd_pkg.sv
// sd_pkg: shared constants and helpers for the sigma-delta receive path.
//   integ_width - width of the sinc2 integrators/combs for a given LOG2R.
//   sat_trunc   - maps a raw sinc2 output in [0, R^2] to an out_w-bit code.
//                 The value saturates to all-ones when bit 2*log2r is set.
//                 Otherwise the top out_w bits below that bit are kept.
package sd_pkg;

   // Two cascaded integrators of a 1-bit stream over R samples reach R^2,
   // which needs 2*LOG2R+1 bits to hold exactly.
   function automatic int integ_width(input int log2r);
      return 2 * log2r + 1;
   endfunction

   // Saturate-or-truncate scaling. Widths up to 32 bits are carried in a
   // fixed container; the caller narrows the result to its output width.
   function automatic logic [31:0] sat_trunc(input logic [31:0] yraw,
                                             input int          log2r,
                                             input int          out_w);
      logic [31:0] mask;
      logic [31:0] res;
      mask = (32'd1 << out_w) - 32'd1;
      if (yraw[2 * log2r]) begin
         res = mask;
      end else begin
         res = (yraw >> (2 * log2r - out_w)) & mask;
      end
      return res;
   endfunction

endpackage

// File: rtl/sd_demod_bit_sync.sv
// bit_sync: STAGES-deep flop chain that brings an asynchronous 1-bit input
// into the clk domain. The chain clears to 0 on reset.
//   clk   - system clock
//   reset - synchronous, active-high reset
//   d     - asynchronous input bit
//   q     - synchronized bit (last stage of the chain)
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the input through the synchronizer chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= {STAGES{1'b0}};
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/sd_demod.sv
// sd_demod: recovers a parallel value from a first-order sigma-delta
// bitstream. The path is: synchronizer -> sinc2 (two integrators, two combs)
// decimating by R = 2^LOG2R -> saturating scale to OUT_W bits.
//   clk     - system clock
//   reset   - synchronous, active-high reset
//   x_in    - sigma-delta bitstream, may be asynchronous to clk
//   y       - decoded value, ones-density * 2^OUT_W, saturated
//   y_valid - one-cycle strobe per decimation window once warmed up
// All integrator/comb arithmetic is modulo 2^W. Integrator wrap is expected;
// the comb differences recover the exact window result despite it.
module sd_demod
   import sd_pkg::*;
#(
   parameter int LOG2R       = 10,
   parameter int OUT_W       = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x_in,
   output logic [OUT_W-1:0] y,
   output logic             y_valid
);

   localparam int               W          = integ_width(LOG2R);
   localparam logic [LOG2R-1:0] PHASE_LAST = {LOG2R{1'b1}};
   localparam logic [LOG2R-1:0] PHASE_ZERO = {LOG2R{1'b0}};
   localparam logic [1:0]       WARM_DONE  = 2'd2;

   logic             b;
   logic [W-1:0]     i1;
   logic [W-1:0]     i2;
   logic [W-1:0]     c1;
   logic [W-1:0]     d1;
   logic [W-1:0]     d2;
   logic [W-1:0]     yraw;
   logic [OUT_W-1:0] y_next;
   logic [LOG2R-1:0] phase;
   logic [1:0]       warm;

   bit_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (x_in),
      .q    (b)
   );

   // Second comb output and its scaled form, consumed on the phase-0 edge.
   always_comb begin
      yraw   = c1 - d2;
      y_next = OUT_W'(sat_trunc(32'(yraw), LOG2R, OUT_W));
   end

   // Integrators, phase counter, both combs, warm-up counter and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         i1      <= {W{1'b0}};
         i2      <= {W{1'b0}};
         c1      <= {W{1'b0}};
         d1      <= {W{1'b0}};
         d2      <= {W{1'b0}};
         phase   <= PHASE_ZERO;
         warm    <= 2'd0;
         y       <= {OUT_W{1'b0}};
         y_valid <= 1'b0;
      end else begin
         i1      <= i1 + {{(W-1){1'b0}}, b};
         i2      <= i2 + i1;
         phase   <= phase + LOG2R'(1);
         y_valid <= 1'b0;
         if (phase == PHASE_LAST) begin
            c1 <= i2 - d1;
            d1 <= i2;
         end
         // Decimation event. The first two results still carry start-up
         // history, so y loads but the strobe stays low until warm.
         if (phase == PHASE_ZERO) begin
            d2      <= c1;
            y       <= y_next;
            y_valid <= (warm == WARM_DONE);
            if (warm != WARM_DONE) begin
               warm <= warm + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_demod.sv
// Self-checking bench for sd_demod (LOG2R=10, OUT_W=10, SYNC_STAGES=2).
// The reference model works from the bitstream itself. Each decimation
// result is the sum over R consecutive sliding windows of the window
// ones-count, giving triangular weights over 2R-1 synchronized bits. The
// result is then scaled to OUT_W bits with saturation. The model tracks the
// reset edge, the event schedule and warm-up from those rules alone.
module tb_sd_demod;

   localparam int LOG2R = 10;
   localparam int OUT_W = 10;
   localparam int R     = 1 << LOG2R;
   localparam int MAXC  = 65536;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             x_in = 1'b0;
   logic [OUT_W-1:0] y;
   logic             y_valid;

   sd_demod #(.LOG2R(LOG2R), .OUT_W(OUT_W), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .x_in(x_in), .y(y), .y_valid(y_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int src;    // 0 = constant level, 1 = first-order SD DAC
      int v;      // constant bit or DAC code
      int exp_y;  // required steady-state output
   } vec_t;

   int tests = 0;
   int fails = 0;
   bit xh[MAXC];
   bit rh[MAXC];
   int n = 0;
   int rst_edge = -1;
   int y_model = 0;

   int src_mode = 0;
   bit cval = 1'b0;
   int dac_v = 0;
   int dac_acc = 0;
   bit alt = 1'b0;
   int strobes = 0;
   int last_y = 0;
   int last_strobe_n = 0;
   int period = 0;

   task automatic check(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", name, n, got, want);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      tests++;
      if (got < lo || got > hi) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d..%0d", name, n, got, lo, hi);
      end
   endtask

   // Synchronized bit during cycle u: x_in two cycles earlier, 0 after reset.
   function automatic int b_of(input int u);
      if (u < rst_edge + 2 || u < 2) return 0;
      return int'(xh[u-2]);
   endfunction

   // Expected y after decimation event on edge e.
   function automatic int model_y(input int e);
      int t, acc, lo, hi, w;
      t = e - 2;
      acc = 0;
      for (int u = t - 2 * R; u <= t - 2; u++) begin
         lo = (u + 1 > t - R) ? u + 1 : t - R;
         hi = (u + R < t - 1) ? u + R : t - 1;
         w = hi - lo + 1;
         if (w > 0) acc += w * b_of(u);
      end
      if (acc >= R * R) return (1 << OUT_W) - 1;
      return acc >> (2 * LOG2R - OUT_W);
   endfunction

   // One clock: record inputs, advance, check against the model, drive next bit.
   task automatic tick();
      bit nb;
      int exp_v;
      if (n >= MAXC - 1) begin
         $display("FAIL cycle_budget: reached %0d cycles", n);
         $fatal(1);
      end
      xh[n] = x_in;
      rh[n] = reset;
      @(posedge clk);
      n++;
      #1;
      exp_v = 0;
      if (rh[n-1]) begin
         rst_edge = n;
         y_model = 0;
      end else if (rst_edge >= 0 && (n - rst_edge - 1) % R == 0) begin
         y_model = model_y(n);
         exp_v = ((n - rst_edge - 1) / R >= 2) ? 1 : 0;
      end
      if (rst_edge >= 0) begin
         check("y_valid", int'(y_valid), exp_v);
         check("y", int'(y), y_model);
      end
      if (y_valid === 1'b1) begin
         if (strobes > 0) period = n - last_strobe_n;
         last_strobe_n = n;
         last_y = int'(y);
         strobes++;
      end
      case (src_mode)
         0: nb = cval;
         1: begin
            dac_acc += dac_v;
            if (dac_acc >= R) begin
               dac_acc -= R;
               nb = 1'b1;
            end else begin
               nb = 1'b0;
            end
         end
         default: begin
            alt = ~alt;
            nb = alt;
            #($urandom_range(0, 3));
         end
      endcase
      x_in = nb;
   endtask

   task automatic run(input int cycles);
      repeat (cycles) tick();
   endtask

   task automatic wait_strobe(output int val);
      int prev, k;
      prev = strobes;
      k = 0;
      while (strobes == prev && k < 2 * R + 8) begin
         tick();
         k++;
      end
      tests++;
      if (strobes == prev) begin
         fails++;
         $display("FAIL strobe_timeout: no y_valid within %0d cycles", 2 * R + 8);
      end
      val = last_y;
   endtask

   initial begin
      vec_t tbl[8];
      int v, s0;
      tbl[0] = '{src: 0, v: 0,    exp_y: 0};
      tbl[1] = '{src: 0, v: 1,    exp_y: 1023};
      tbl[2] = '{src: 1, v: 1,    exp_y: 1};
      tbl[3] = '{src: 1, v: 256,  exp_y: 256};
      tbl[4] = '{src: 1, v: 511,  exp_y: 511};
      tbl[5] = '{src: 1, v: 512,  exp_y: 512};
      tbl[6] = '{src: 1, v: 1000, exp_y: 1000};
      tbl[7] = '{src: 1, v: 1023, exp_y: 1023};

      // Reset, then constant 0: two silent windows, then y = 0 strobes.
      reset = 1'b1;
      src_mode = 0;
      cval = 1'b0;
      run(4);
      check("reset_y", int'(y), 0);
      check("reset_y_valid", int'(y_valid), 0);
      reset = 1'b0;
      s0 = strobes;
      run(2 * R);
      check("warmup_quiet", strobes - s0, 0);
      wait_strobe(v);
      check("first_strobe_y", v, 0);

      // Steady-state table: constants and DAC loopback codes.
      foreach (tbl[i]) begin
         src_mode = tbl[i].src;
         cval = (tbl[i].v != 0);
         dac_v = tbl[i].v;
         run(2 * R + 8);
         wait_strobe(v);
         check($sformatf("steady_v%0d_src%0d", tbl[i].v, tbl[i].src), v, tbl[i].exp_y);
      end

      // Constant 1: saturated, strobe period exactly R, one-cycle pulse.
      src_mode = 0;
      cval = 1'b1;
      run(2 * R + 8);
      wait_strobe(v);
      wait_strobe(v);
      check("sat_y", v, 1023);
      check("strobe_period", period, R);
      tick();
      check("pulse_width", int'(y_valid), 0);
      check("y_hold", int'(y), 1023);

      // Long run at constant 1 (integrators wrap), then DAC 300.
      run(2 * R);
      src_mode = 1;
      dac_v = 300;
      run(2 * R + 8);
      wait_strobe(v);
      check("after_wrap_v300", v, 300);

      // Step 100 -> 900 placed 4 cycles ahead of a strobe.
      dac_v = 100;
      run(2 * R + 8);
      wait_strobe(v);
      run(R - 5);
      dac_v = 900;
      wait_strobe(v);
      check("step_pre", v, 100);
      wait_strobe(v);
      check_range("step_mid", v, 101, 899);
      wait_strobe(v);
      check("step_post", v, 900);

      // One-cycle reset mid-window with DAC 700.
      dac_v = 700;
      run(2 * R + 8);
      wait_strobe(v);
      run(R / 2);
      reset = 1'b1;
      tick();
      check("midreset_y", int'(y), 0);
      check("midreset_y_valid", int'(y_valid), 0);
      reset = 1'b0;
      s0 = strobes;
      run(2 * R);
      check("midreset_quiet", strobes - s0, 0);
      wait_strobe(v);
      check_range("midreset_first", v, 699, 700);
      wait_strobe(v);
      check("midreset_v700", v, 700);

      // 50% density toggled with random phase jitter against clk.
      src_mode = 2;
      run(2 * R + 8);
      wait_strobe(v);
      check_range("jitter_y", v, 510, 514);
      wait_strobe(v);
      check_range("jitter_y2", v, 510, 514);
      check("jitter_no_x", int'($isunknown(y)), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
